// File: rtl/dtc_cmd_if.sv
// Register-access command bus into the DTC command transmitter.
// The bus master drives the command fields and the transmitter returns cmd_ready.
interface dtc_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_address,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_address,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/dtc_cmd_tx.sv
// Serialises trigger, control and register-access commands onto the single-wire
// DTC command line as MSB-first frames: start bit, 4-bit code, optional payload.
module dtc_cmd_tx (
  input  logic     dtc_clk,
  input  logic     rst,
  input  logic     trig_l0,
  input  logic     trig_l1,
  input  logic     rstcmd,
  input  logic     rdocmd,
  input  logic     streq,
  dtc_cmd_if.slave cmd,
  output logic     dtc_trig,
  output logic     busy,
  output logic     overrun
);

  localparam int FRAME_W = 69;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state;
  logic [4:0]           pend;
  logic [FRAME_W-1:0]   sreg;
  logic [6:0]           bit_cnt;
  logic [6:0]           frame_len;
  logic                 gap_cnt;

  logic [4:0]           req;
  logic [4:0]           eff;
  logic [4:0]           sel;
  logic [4:0]           pend_nxt;
  logic                 cmd_accept;
  logic                 load;
  logic [FRAME_W-1:0]   frame_nxt;
  logic [6:0]           len_nxt;

  // Bit order of the request vectors is also the priority order, MSB highest.
  function automatic logic [4:0] pick(input logic [4:0] e);
    if (e[4])      return 5'b10000;
    else if (e[3]) return 5'b01000;
    else if (e[2]) return 5'b00100;
    else if (e[1]) return 5'b00010;
    else if (e[0]) return 5'b00001;
    else           return 5'b00000;
  endfunction

  function automatic logic [3:0] code_of(input logic [4:0] s);
    if (s[4])      return 4'b0001;
    else if (s[3]) return 4'b0010;
    else if (s[2]) return 4'b0100;
    else if (s[1]) return 4'b0011;
    else           return 4'b0101;
  endfunction

  assign req = {trig_l0, trig_l1, rstcmd, rdocmd, streq};
  assign eff = pend | req;
  assign sel = (state == IDLE) ? pick(eff) : 5'b00000;

  // A selected flag survives only if a fresh pulse lands in the same cycle.
  assign pend_nxt = (eff & ~sel) | (sel & pend & req);

  assign cmd.cmd_ready = ~rst & (state == IDLE) & ~(|pend) & ~(|req);
  assign cmd_accept    = cmd.cmd_valid & cmd.cmd_ready;
  assign load          = (|sel) | cmd_accept;

  assign overrun = ~rst & (|(req & pend & ~sel));
  assign busy    = ~rst & ((state != IDLE) | (|pend));

  always_comb begin
    frame_nxt = '0;
    len_nxt   = 7'd0;
    if (|sel) begin
      frame_nxt = {1'b1, code_of(sel), 64'd0};
      len_nxt   = 7'd5;
    end else if (cmd.cmd_write) begin
      frame_nxt = {1'b1, 4'b1000, cmd.cmd_address, cmd.cmd_data};
      len_nxt   = 7'd69;
    end else begin
      frame_nxt = {1'b1, 4'b1001, cmd.cmd_address, 32'd0};
      len_nxt   = 7'd37;
    end
  end

  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      frame_len <= '0;
      gap_cnt   <= 1'b0;
      dtc_trig  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      case (state)
        IDLE: begin
          dtc_trig <= 1'b0;
          if (load) begin
            dtc_trig  <= frame_nxt[FRAME_W-1];
            sreg      <= {frame_nxt[FRAME_W-2:0], 1'b0};
            frame_len <= len_nxt;
            bit_cnt   <= 7'd1;
            state     <= SEND;
          end
        end
        // bit_cnt counts bits already on the line, so the frame ends once it hits frame_len.
        SEND: begin
          if (bit_cnt == frame_len) begin
            dtc_trig <= 1'b0;
            bit_cnt  <= 7'd0;
            gap_cnt  <= 1'b0;
            state    <= GAP;
          end else begin
            dtc_trig <= sreg[FRAME_W-1];
            sreg     <= {sreg[FRAME_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 7'd1;
          end
        end
        GAP: begin
          dtc_trig <= 1'b0;
          if (gap_cnt) state <= IDLE;
          else         gap_cnt <= 1'b1;
        end
        default: begin
          dtc_trig <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
